striping_nlane: RTL and testbench

Parametrised N-lane byte-striping block for the PHY transmit path, successor to the two-lane striper. Accepts one WIDTH-bit word per clk_2f cycle and distributes accepted words round-robin across NUM_LANES lane registers, each with its own one-cycle valid pulse. Adds a ready handshake, explicit flush-with-padding of a partial lane group, and a group-complete strobe. Sits between the byte-unstriping/FIFO source and the per-lane serialisers.

---
 rtl/striping_nlane.sv | 123 ++++++++++++
 tb/tb_striping_nlane.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/striping_nlane.sv
// Purpose : round-robin striping of accepted words across NUM_LANES lane registers,
//           with flush-with-padding of a partial group and a group-complete strobe.
// Latency : one cycle from the accepting clk_2f edge to lane_out/valid_out.
// Backpr. : ready is low only while padding out a flushed group; source must hold/drop words then.
// Ports   : clk_2f, reset (async, active-low); data_in/valid_in/ready word handshake;
//           flush pads the current partial group; lane_out/valid_out per-lane data and strobes;
//           pad_out marks pad writes; group_done marks a write to the last lane;
//           lane_ptr is the next lane to be written.
// Option  : STRIPING_PARITY_EN adds parity_out, registered even parity of each lane's last word.
module striping_nlane #(
  parameter int               NUM_LANES = 4,
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] PAD_WORD  = {WIDTH{1'b0}}
) (
  input  logic                          clk_2f,
  input  logic                          reset,
  input  logic [WIDTH-1:0]              data_in,
  input  logic                          valid_in,
  input  logic                          flush,
  output logic                          ready,
  output logic [NUM_LANES*WIDTH-1:0]    lane_out,
  output logic [NUM_LANES-1:0]          valid_out,
  output logic                          pad_out,
  output logic                          group_done,
  output logic [$clog2(NUM_LANES)-1:0]  lane_ptr
`ifdef STRIPING_PARITY_EN
  ,
  output logic [NUM_LANES-1:0]          parity_out
`endif
);

  localparam int               PTR_W = $clog2(NUM_LANES);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(NUM_LANES - 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t           state, state_nxt;
  logic             wr_en;
  logic             wr_pad;
  logic [WIDTH-1:0] wr_dat;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] ptr_nxt;

  assign ready = (state == IDLE);

  // Explicit wrap so non-power-of-two lane counts never reach an unused pointer value.
  assign ptr_inc = (lane_ptr == LAST) ? '0 : lane_ptr + PTR_W'(1);

  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = lane_ptr;
    wr_en     = 1'b0;
    wr_pad    = 1'b0;
    wr_dat    = data_in;
    case (state)
      IDLE: begin
        if (valid_in) begin
          wr_en   = 1'b1;
          ptr_nxt = ptr_inc;
        end
        // Flush looks at the pointer after this cycle's write: a word that
        // completes the group makes the flush a no-op.
        if (flush && (ptr_nxt != '0)) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        wr_en   = 1'b1;
        wr_pad  = 1'b1;
        wr_dat  = PAD_WORD;
        ptr_nxt = ptr_inc;
        if (lane_ptr == LAST) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      lane_out   <= '0;
      valid_out  <= '0;
      pad_out    <= 1'b0;
      group_done <= 1'b0;
      lane_ptr   <= '0;
    end else begin
      valid_out  <= '0;
      pad_out    <= wr_pad;
      group_done <= wr_en && (lane_ptr == LAST);
      lane_ptr   <= ptr_nxt;
      for (int i = 0; i < NUM_LANES; i++) begin
        if (wr_en && (lane_ptr == PTR_W'(i))) begin
          valid_out[i]                <= 1'b1;
          lane_out[i*WIDTH +: WIDTH]  <= wr_dat;
        end
      end
    end
  end

`ifdef STRIPING_PARITY_EN
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      parity_out <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (wr_en && (lane_ptr == PTR_W'(i))) begin
          parity_out[i] <= ^wr_dat;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_striping_nlane.sv
// Purpose : exercises a 4-lane and a 3-lane striper side by side from shared stimulus.
// Latency : expectations are one cycle behind the accepting edge.
// Backpr. : the reference model tracks remaining pad cycles to predict ready.
module tb_striping_nlane;

  logic        clk_2f = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic        valid_in;
  logic        flush;

  logic         ready4, ready3;
  logic [127:0] lane4;
  logic [95:0]  lane3;
  logic [3:0]   valid4;
  logic [2:0]   valid3;
  logic         pad4, pad3, gd4, gd3;
  logic [1:0]   ptr4, ptr3;
`ifdef STRIPING_PARITY_EN
  logic [3:0]   par4;
  logic [2:0]   par3;
`endif

  always #5 clk_2f = ~clk_2f;

  striping_nlane #(.NUM_LANES(4), .WIDTH(32)) dut4 (
    .clk_2f(clk_2f), .reset(reset), .data_in(data_in), .valid_in(valid_in), .flush(flush),
    .ready(ready4), .lane_out(lane4), .valid_out(valid4), .pad_out(pad4),
    .group_done(gd4), .lane_ptr(ptr4)
`ifdef STRIPING_PARITY_EN
    , .parity_out(par4)
`endif
  );

  striping_nlane #(.NUM_LANES(3), .WIDTH(32)) dut3 (
    .clk_2f(clk_2f), .reset(reset), .data_in(data_in), .valid_in(valid_in), .flush(flush),
    .ready(ready3), .lane_out(lane3), .valid_out(valid3), .pad_out(pad3),
    .group_done(gd3), .lane_ptr(ptr3)
`ifdef STRIPING_PARITY_EN
    , .parity_out(par3)
`endif
  );

  int checks = 0;
  int errors = 0;
  int gd4_cnt = 0;

  // Reference model: index 0 is the 4-lane instance, index 1 the 3-lane one.
  int          m_n    [2];
  int          m_pos  [2];   // words placed in the current group
  int          m_pads [2];   // pad writes still owed by a flush
  logic [31:0] m_lane [2][16];
  logic        m_par  [2][16];
  logic [15:0] exp_valid [2];
  logic        exp_pad   [2];
  logic        exp_gd    [2];

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_pos[m] = 0; m_pads[m] = 0;
      exp_valid[m] = '0; exp_pad[m] = 1'b0; exp_gd[m] = 1'b0;
      for (int i = 0; i < 16; i++) begin
        m_lane[m][i] = '0; m_par[m][i] = 1'b0;
      end
    end
  endtask

  task automatic model_put(input int m, input logic [31:0] w);
    m_lane[m][m_pos[m]] = w;
    m_par[m][m_pos[m]]  = ^w;
    exp_valid[m]        = 16'(1) << m_pos[m];
    exp_gd[m]           = (m_pos[m] == m_n[m] - 1);
    m_pos[m]            = (m_pos[m] + 1) % m_n[m];
  endtask

  task automatic model_step(input int m, input bit v, input bit f, input logic [31:0] d);
    exp_valid[m] = '0; exp_pad[m] = 1'b0; exp_gd[m] = 1'b0;
    if (m_pads[m] > 0) begin
      model_put(m, 32'h0);
      exp_pad[m] = 1'b1;
      m_pads[m]--;
    end else begin
      if (v) model_put(m, d);
      if (f && m_pos[m] != 0) m_pads[m] = m_n[m] - m_pos[m];
    end
  endtask

  function automatic logic [127:0] exp_lanes(input int m);
    logic [127:0] r = '0;
    for (int i = 0; i < m_n[m]; i++) r[i*32 +: 32] = m_lane[m][i];
    return r;
  endfunction

  function automatic logic [127:0] exp_par(input int m);
    logic [127:0] r = '0;
    for (int i = 0; i < m_n[m]; i++) r[i] = m_par[m][i];
    return r;
  endfunction

  task automatic compare_all();
    check("lane4",  128'(lane4),  exp_lanes(0));
    check("lane3",  128'(lane3),  exp_lanes(1));
    check("valid4", 128'(valid4), 128'(exp_valid[0]));
    check("valid3", 128'(valid3), 128'(exp_valid[1]));
    check("pad4",   128'(pad4),   128'(exp_pad[0]));
    check("pad3",   128'(pad3),   128'(exp_pad[1]));
    check("gd4",    128'(gd4),    128'(exp_gd[0]));
    check("gd3",    128'(gd3),    128'(exp_gd[1]));
    check("ptr4",   128'(ptr4),   128'(m_pos[0]));
    check("ptr3",   128'(ptr3),   128'(m_pos[1]));
`ifdef STRIPING_PARITY_EN
    check("par4",   128'(par4),   exp_par(0));
    check("par3",   128'(par3),   exp_par(1));
`endif
    if (gd4) gd4_cnt++;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input bit v, input bit f, input logic [31:0] d);
    valid_in = v; flush = f; data_in = d;
    check("ready4", 128'(ready4), 128'(m_pads[0] == 0));
    check("ready3", 128'(ready3), 128'(m_pads[1] == 0));
    model_step(0, v, f, d);
    model_step(1, v, f, d);
    @(posedge clk_2f);
    #1;
    compare_all();
    @(negedge clk_2f);
    valid_in = 1'b0; flush = 1'b0;
  endtask

  // Asynchronous reset applied away from any clock edge; checked immediately.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("rst_ready4", 128'(ready4), 128'(1));
    check("rst_ready3", 128'(ready3), 128'(1));
    @(negedge clk_2f);
    reset = 1'b1;
  endtask

  logic [31:0] seq8 [8];

  initial begin
    m_n[0] = 4; m_n[1] = 3;
    valid_in = 1'b0; flush = 1'b0; data_in = '0;
    seq8 = '{32'hFFFFFFFF, 32'hEEEEEEEE, 32'hDDDDDDDD, 32'hCCCCCCCC, 32'h1, 32'h2, 32'h3, 32'h4};

    // Back-to-back words fill both instances round-robin.
    do_reset();
    gd4_cnt = 0;
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, seq8[i]);
    check("seq8_lanes4", 128'(lane4), 128'h00000004_00000003_00000002_00000001);
    check("seq8_lanes3", 128'(lane3), 128'h00000002_00000004_00000003);
    check("seq8_gd_cnt", 128'(gd4_cnt), 128'(2));
    check("seq8_ptr4",   128'(ptr4), 128'(0));

    // Gaps hold lanes and produce no strobes.
    do_reset();
    cycle(1'b1, 1'b0, 32'hBBBBBBBB);
    cycle(1'b0, 1'b0, $urandom);
    cycle(1'b0, 1'b0, $urandom);
    cycle(1'b1, 1'b0, 32'h1);
    cycle(1'b1, 1'b0, 32'h2);
    check("gap_lanes4", 128'(lane4[95:0]), 128'h00000002_00000001_BBBBBBBB);

    // Flush after two words pads lanes 2 and 3; words offered meanwhile are ignored.
    do_reset();
    cycle(1'b1, 1'b0, 32'hAAAAAAAA);
    cycle(1'b1, 1'b0, 32'h11111111);
    cycle(1'b0, 1'b1, 32'h0);
    cycle(1'b1, 1'b0, 32'h99999999);
    cycle(1'b1, 1'b0, 32'h98989898);
    check("flush_lanes4", 128'(lane4), 128'h00000000_00000000_11111111_AAAAAAAA);
    cycle(1'b0, 1'b0, 32'h0);

    // Word plus flush that completes the group: no padding follows.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, $urandom);
    cycle(1'b1, 1'b1, 32'h5);
    check("wf_lane3", 128'(lane4[127:96]), 128'h5);
    check("wf_ready", 128'(ready4), 128'(1));
    cycle(1'b0, 1'b0, 32'h0);

    // Reset while padding discards the group.
    do_reset();
    cycle(1'b1, 1'b0, 32'h12345678);
    cycle(1'b1, 1'b0, 32'h9ABCDEF0);
    cycle(1'b0, 1'b1, 32'h0);
    check("inflush_ptr4",   128'(ptr4),   128'(2));
    check("inflush_ready4", 128'(ready4), 128'(0));
    do_reset();
    cycle(1'b1, 1'b0, 32'h0000CAFE);
    check("postrst_valid4", 128'(valid4), 128'(4'b0001));

`ifdef STRIPING_PARITY_EN
    do_reset();
    cycle(1'b1, 1'b0, 32'h00000001);
    cycle(1'b1, 1'b0, 32'h00000003);
    check("par3_01_03", 128'(par3[1:0]), 128'(2'b01));
`endif

    // Randomised traffic with occasional flushes and asynchronous resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, $urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
